// File: rtl/test_pattern_gen_if.sv
// Video stream bundle between the pattern source and its sink (upscaler).
//   stall       : sink -> source, freeze the raster this cycle
//   px, py      : current pixel column / line
//   rgb         : packed {R,G,B} pixel for (px,py)
//   de          : (px,py) lies inside the active screen
//   new_frame   : one-cycle pulse after a frame wrap
//   frame_count : completed frames, wrapping
interface test_pattern_gen_if #(
    parameter int XW = 9,
    parameter int YW = 9,
    parameter int CW = 8
);
    logic            stall;
    logic [XW-1:0]   px;
    logic [YW-1:0]   py;
    logic [3*CW-1:0] rgb;
    logic            de;
    logic            new_frame;
    logic [15:0]     frame_count;

    modport master (input stall, output px, py, rgb, de, new_frame, frame_count);
    modport slave  (output stall, input px, py, rgb, de, new_frame, frame_count);
endinterface

// File: rtl/test_pattern_gen.sv
// PPU-domain video test source. Scans a raster at the pixel clock, honours
// stall backpressure from the sink and emits a registered pixel aligned with
// px/py. Patterns: 0 border/checker, 1 solid, 2 gradient, 3 colour bars,
// 4 bouncing box, 5-7 as 0.
//   clk_p      : pixel clock
//   rst_p_n    : asynchronous active-low reset
//   mode       : pattern select, latched at frame wrap only
//   solid_rgb  : colour used by mode 1, sampled on every advance
//   vid        : video stream (stall in; px/py/rgb/de/new_frame/frame_count out)
module test_pattern_gen #(
    parameter int ISCREEN_WIDTH  = 256,
    parameter int ISCREEN_HEIGHT = 240,
    parameter int IFRAME_WIDTH   = 341,
    parameter int IFRAME_HEIGHT  = 262,
    parameter int XW             = 9,
    parameter int YW             = 9,
    parameter int CW             = 8,
    parameter int BOX_SIZE       = 16,
    parameter int BAR_SHIFT      = 5
) (
    input  logic                 clk_p,
    input  logic                 rst_p_n,
    input  logic [2:0]           mode,
    input  logic [3*CW-1:0]      solid_rgb,
    test_pattern_gen_if.master   vid
);

    localparam int XMAX = ISCREEN_WIDTH - BOX_SIZE;
    localparam int YMAX = ISCREEN_HEIGHT - BOX_SIZE;
    localparam logic [CW-1:0] FULL = {CW{1'b1}};

    // 8-bit value placed in the top bits of a CW-bit channel
    function automatic logic [CW-1:0] lvl(input logic [7:0] v);
        return CW'(v) << (CW - 8);
    endfunction

    logic [XW-1:0]   px_r, px_n, box_x, bx_n;
    logic [YW-1:0]   py_r, py_n, box_y, by_n;
    logic [3*CW-1:0] rgb_r, pix;
    logic            de_r, de_n, nf_r;
    logic [15:0]     fc_r, fc_n;
    logic [2:0]      mode_r, mode_n, bar;
    logic            dir_x, dir_y, dx_n, dy_n;
    logic            last_px, wrap, in_box, border;

    // Next raster position and frame-level state; the pixel is rendered
    // from these so the registered rgb/de match the registered px/py.
    always_comb begin
        last_px = (px_r == XW'(IFRAME_WIDTH - 1));
        wrap    = last_px && (py_r == YW'(IFRAME_HEIGHT - 1));
        px_n    = last_px ? '0 : px_r + XW'(1);
        py_n    = py_r;
        if (last_px)
            py_n = wrap ? '0 : py_r + YW'(1);
        mode_n  = wrap ? mode : mode_r;
        fc_n    = wrap ? fc_r + 16'd1 : fc_r;

        // Box bounces off the edges: the step that hits a wall already
        // moves one pixel back the other way.
        bx_n = box_x;
        dx_n = dir_x;
        by_n = box_y;
        dy_n = dir_y;
        if (wrap) begin
            if (!dir_x) begin
                if (box_x == XW'(XMAX)) begin dx_n = 1'b1; bx_n = XW'(XMAX - 1); end
                else                           bx_n = box_x + XW'(1);
            end else begin
                if (box_x == '0) begin dx_n = 1'b0; bx_n = XW'(1); end
                else                  bx_n = box_x - XW'(1);
            end
            if (!dir_y) begin
                if (box_y == YW'(YMAX)) begin dy_n = 1'b1; by_n = YW'(YMAX - 1); end
                else                           by_n = box_y + YW'(1);
            end else begin
                if (box_y == '0) begin dy_n = 1'b0; by_n = YW'(1); end
                else                  by_n = box_y - YW'(1);
            end
        end
    end

    // Pixel render; one extra bit on the compares keeps box_x+BOX_SIZE exact
    always_comb begin
        de_n   = ({1'b0, px_n} < (XW+1)'(ISCREEN_WIDTH)) &&
                 ({1'b0, py_n} < (YW+1)'(ISCREEN_HEIGHT));
        in_box = ({1'b0, px_n} >= {1'b0, bx_n}) &&
                 ({1'b0, px_n} <  {1'b0, bx_n} + (XW+1)'(BOX_SIZE)) &&
                 ({1'b0, py_n} >= {1'b0, by_n}) &&
                 ({1'b0, py_n} <  {1'b0, by_n} + (YW+1)'(BOX_SIZE));
        border = (px_n == '0) || (py_n == '0) ||
                 (px_n == XW'(ISCREEN_WIDTH - 1)) || (py_n == YW'(ISCREEN_HEIGHT - 1));
        bar    = 3'(px_n >> BAR_SHIFT);
        pix    = '0;
        case (mode_n)
            3'd1: pix = solid_rgb;
            3'd2: pix = {lvl(8'(px_n)), lvl(8'(py_n)), lvl(8'(fc_n))};
            3'd3: pix = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
            3'd4: pix = in_box ? {FULL, FULL, FULL} : '0;
            default: begin
                if (border)
                    pix = {FULL, FULL, FULL};
                else if (px_n[0] ^ py_n[0])
                    pix = {lvl(8'(px_n)), lvl(8'(py_n)), {CW{1'b0}}};
            end
        endcase
        if (!de_n)
            pix = '0;
    end

    always_ff @(posedge clk_p or negedge rst_p_n) begin
        if (!rst_p_n) begin
            px_r   <= '0;
            py_r   <= '0;
            rgb_r  <= {FULL, FULL, FULL};
            de_r   <= 1'b1;
            nf_r   <= 1'b0;
            fc_r   <= '0;
            mode_r <= '0;
            box_x  <= '0;
            box_y  <= '0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
        end else begin
            // pulse drops on any edge, stalled or not
            nf_r <= !vid.stall && wrap;
            if (!vid.stall) begin
                px_r   <= px_n;
                py_r   <= py_n;
                rgb_r  <= pix;
                de_r   <= de_n;
                fc_r   <= fc_n;
                mode_r <= mode_n;
                box_x  <= bx_n;
                box_y  <= by_n;
                dir_x  <= dx_n;
                dir_y  <= dy_n;
            end
        end
    end

    assign vid.px          = px_r;
    assign vid.py          = py_r;
    assign vid.rgb         = rgb_r;
    assign vid.de          = de_r;
    assign vid.new_frame   = nf_r;
    assign vid.frame_count = fc_r;

endmodule

// File: tb/tb_test_pattern_gen.sv
module tb_test_pattern_gen;
    localparam int ISW = 24, ISH = 20, IFW = 30, IFH = 22;
    localparam int XW = 9, YW = 9, CW = 8, BOX = 8, BSH = 1;
    localparam int XMAX = ISW - BOX, YMAX = ISH - BOX;
    localparam int FRAME = IFW * IFH;

    logic          clk_p = 1'b0;
    logic          rst_p_n = 1'b1;
    logic [2:0]    mode = 3'd0;
    logic [23:0]   solid_rgb = '0;

    test_pattern_gen_if #(.XW(XW), .YW(YW), .CW(CW)) vid ();

    test_pattern_gen #(
        .ISCREEN_WIDTH(ISW), .ISCREEN_HEIGHT(ISH), .IFRAME_WIDTH(IFW),
        .IFRAME_HEIGHT(IFH), .XW(XW), .YW(YW), .CW(CW), .BOX_SIZE(BOX),
        .BAR_SHIFT(BSH)
    ) dut (
        .clk_p(clk_p), .rst_p_n(rst_p_n), .mode(mode),
        .solid_rgb(solid_rgb), .vid(vid)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        int          px, py, fc;
        logic [23:0] rgb;
        logic        de, nf;
    } exp_t;

    exp_t sb[$];
    exp_t prev;
    int   n_chk = 0, n_fail = 0;
    int   m_px, m_py, m_mode, m_fc, m_bx, m_by, m_dx, m_dy;
    int   cyc = 0, last_nf_cyc = 0, nf_gap = 0;
    logic cur_nf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pix(int x, int y, int md, int fc, int bx, int by,
                                        logic [23:0] sol);
        int b;
        if (x >= ISW || y >= ISH) return 24'h0;
        case (md)
            1: return sol;
            2: return {8'(x), 8'(y), 8'(fc)};
            3: begin
                b = (x >> BSH) & 7;
                return {((b & 4) != 0) ? 8'hFF : 8'h00,
                        ((b & 2) != 0) ? 8'hFF : 8'h00,
                        ((b & 1) != 0) ? 8'hFF : 8'h00};
            end
            4: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFFFFFF : 24'h0;
            default: begin
                if (x == 0 || y == 0 || x == ISW - 1 || y == ISH - 1) return 24'hFFFFFF;
                if (((x ^ y) & 1) == 1) return {8'(x), 8'(y), 8'h00};
                return 24'h0;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_mode = 0; m_fc = 0;
        m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
        prev.px = 0; prev.py = 0; prev.fc = 0;
        prev.rgb = 24'hFFFFFF; prev.de = 1'b1; prev.nf = 1'b0;
        sb.delete();
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step(input bit st);
        exp_t e;
        bit wrap;
        vid.stall = st;
        solid_rgb = 24'($urandom);
        if (!st) begin
            wrap = (m_px == IFW - 1 && m_py == IFH - 1);
            if (m_px == IFW - 1) begin
                m_px = 0;
                m_py = (m_py == IFH - 1) ? 0 : m_py + 1;
            end else m_px++;
            if (wrap) begin
                m_mode = mode;
                m_fc = (m_fc + 1) & 16'hFFFF;
                if (m_dx == 0) begin if (m_bx == XMAX) begin m_dx = 1; m_bx = XMAX - 1; end else m_bx++; end
                else           begin if (m_bx == 0)    begin m_dx = 0; m_bx = 1;        end else m_bx--; end
                if (m_dy == 0) begin if (m_by == YMAX) begin m_dy = 1; m_by = YMAX - 1; end else m_by++; end
                else           begin if (m_by == 0)    begin m_dy = 0; m_by = 1;        end else m_by--; end
            end
            e.px = m_px; e.py = m_py; e.fc = m_fc;
            e.de = (m_px < ISW && m_py < ISH);
            e.rgb = pix(m_px, m_py, m_mode, m_fc, m_bx, m_by, solid_rgb);
            e.nf = wrap;
        end else begin
            e = prev;
            e.nf = 1'b0;
        end
        prev = e;
        sb.push_back(e);
        @(posedge clk_p);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("px", 64'(vid.px), 64'(e.px));
        chk("py", 64'(vid.py), 64'(e.py));
        chk("rgb", 64'(vid.rgb), 64'(e.rgb));
        chk("de", 64'(vid.de), 64'(e.de));
        chk("new_frame", 64'(vid.new_frame), 64'(e.nf));
        chk("frame_count", 64'(vid.frame_count), 64'(e.fc));
        if (vid.new_frame) begin
            nf_gap = cyc - last_nf_cyc;
            last_nf_cyc = cyc;
        end
        // fixed-value spot checks
        if (m_mode == 0 && e.px == 0 && e.py == 0) chk("m0_0_0", 64'(vid.rgb), 64'h FFFFFF);
        if (m_mode == 0 && e.px == 3 && e.py == 2) chk("m0_3_2", 64'(vid.rgb), 64'h030200);
        if (m_mode == 0 && e.px == 2 && e.py == 2) chk("m0_2_2", 64'(vid.rgb), 64'h0);
        if (e.px == 25 && e.py == 10) begin
            chk("oob_de", 64'(vid.de), 64'h0);
            chk("oob_rgb", 64'(vid.rgb), 64'h0);
        end
        if (m_mode == 3 && e.py == 5 && (e.px == 2 || e.px == 3)) chk("bar_blue", 64'(vid.rgb), 64'h0000FF);
        if (m_mode == 3 && e.py == 5 && e.px == 14) chk("bar_white", 64'(vid.rgb), 64'hFFFFFF);
        if (m_mode == 4 && m_bx == XMAX && e.py == m_by) begin
            if (e.px == m_bx + BOX - 1) chk("box_in", 64'(vid.rgb), 64'hFFFFFF);
            if (e.px == m_bx + BOX)     chk("box_out", 64'(vid.rgb), 64'h0);
        end
        cur_nf = e.nf;
    endtask

    task automatic run_frames(input int n, input int stall_mod);
        int done = 0, guard = 0;
        while (done < n && guard < n * FRAME * 3) begin
            step(stall_mod != 0 && ($urandom % stall_mod) == 0);
            if (cur_nf) done++;
            guard++;
        end
        chk("run_frames_done", 64'(done), 64'(n));
    endtask

    task automatic run_until(input int x, input int y);
        int guard = 0;
        while (!(m_px == x && m_py == y) && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
        chk("run_until_reached", 64'(m_px == x && m_py == y), 64'h1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_px"}, 64'(vid.px), 64'h0);
        chk({tag, "_py"}, 64'(vid.py), 64'h0);
        chk({tag, "_rgb"}, 64'(vid.rgb), 64'hFFFFFF);
        chk({tag, "_de"}, 64'(vid.de), 64'h1);
        chk({tag, "_nf"}, 64'(vid.new_frame), 64'h0);
        chk({tag, "_fc"}, 64'(vid.frame_count), 64'h0);
    endtask

    initial begin
        int first_nf;
        vid.stall = 1'b0;
        #2 rst_p_n = 1'b0;
        repeat (3) @(negedge clk_p);
        chk_reset_vals("rst");
        rst_p_n = 1'b1;
        model_reset();
        cyc = 0;

        // first frame: raster scan and first new_frame timing
        first_nf = -1;
        for (int i = 1; i <= FRAME + 5; i++) begin
            step(1'b0);
            if (vid.new_frame) begin first_nf = i; break; end
        end
        chk("first_nf_cyc", 64'(first_nf), 64'(FRAME));
        chk("first_nf_fc", 64'(vid.frame_count), 64'h1);

        // mode change mid-frame takes effect only after the wrap
        repeat (100) step(1'b0);
        mode = 3'd3;
        run_frames(1, 0);

        // stall in the middle of a line, then at the last pixel
        run_until(10, 0);
        repeat (7) step(1'b1);
        step(1'b0);
        chk("stall_resume_px", 64'(vid.px), 64'd11);
        run_until(IFW - 1, IFH - 1);
        repeat (5) step(1'b1);
        step(1'b0);
        chk("stalled_wrap_nf", 64'(vid.new_frame), 64'h1);
        chk("nf_gap", 64'(nf_gap), 64'(FRAME + 12));

        // remaining modes with random stalls
        mode = 3'd1; run_frames(1, 0); run_frames(1, 8);
        mode = 3'd2; run_frames(1, 8);
        mode = 3'd6; run_frames(1, 8);
        mode = 3'd4; run_frames(30, 8);

        // asynchronous reset mid-frame, with mode 3 still requested
        mode = 3'd3;
        repeat (100) step(1'b0);
        #2 rst_p_n = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk_p);
        rst_p_n = 1'b1;
        model_reset();
        cyc = 0;
        last_nf_cyc = 0;
        repeat (100) step(1'b0);
        run_frames(1, 0);
        repeat (200) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
